// File: rtl/kbd_pkg.sv
// Shared PS/2 set-2 scan-code constants and prefix-decoder state encoding.
// Holds no logic beyond a small classification helper.
package kbd_pkg;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  function automatic logic is_prefix(input logic [7:0] code);
    return (code == SC_BRK) || (code == SC_EXT);
  endfunction

endpackage

// File: rtl/scan_xlat.sv
// Combinational scan-code to ASCII lookup for the 48 printable US keys.
// Zero latency, no flow control; o_printable=0 for any code without a glyph.
module scan_xlat (
  input  logic [7:0] i_code,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_ascii,
  output logic       o_printable
);

  logic [7:0] w_base;
  logic [7:0] w_shft;
  logic       w_letter;

  always_comb begin
    w_base = 8'h00;
    w_shft = 8'h00;
    case (i_code)
      8'h1C: w_base = 8'h61;  8'h32: w_base = 8'h62;  8'h21: w_base = 8'h63;
      8'h23: w_base = 8'h64;  8'h24: w_base = 8'h65;  8'h2B: w_base = 8'h66;
      8'h34: w_base = 8'h67;  8'h33: w_base = 8'h68;  8'h43: w_base = 8'h69;
      8'h3B: w_base = 8'h6A;  8'h42: w_base = 8'h6B;  8'h4B: w_base = 8'h6C;
      8'h3A: w_base = 8'h6D;  8'h31: w_base = 8'h6E;  8'h44: w_base = 8'h6F;
      8'h4D: w_base = 8'h70;  8'h15: w_base = 8'h71;  8'h2D: w_base = 8'h72;
      8'h1B: w_base = 8'h73;  8'h2C: w_base = 8'h74;  8'h3C: w_base = 8'h75;
      8'h2A: w_base = 8'h76;  8'h1D: w_base = 8'h77;  8'h22: w_base = 8'h78;
      8'h35: w_base = 8'h79;  8'h1A: w_base = 8'h7A;
      8'h45: begin w_base = 8'h30; w_shft = 8'h29; end
      8'h16: begin w_base = 8'h31; w_shft = 8'h21; end
      8'h1E: begin w_base = 8'h32; w_shft = 8'h40; end
      8'h26: begin w_base = 8'h33; w_shft = 8'h23; end
      8'h25: begin w_base = 8'h34; w_shft = 8'h24; end
      8'h2E: begin w_base = 8'h35; w_shft = 8'h25; end
      8'h36: begin w_base = 8'h36; w_shft = 8'h5E; end
      8'h3D: begin w_base = 8'h37; w_shft = 8'h26; end
      8'h3E: begin w_base = 8'h38; w_shft = 8'h2A; end
      8'h46: begin w_base = 8'h39; w_shft = 8'h28; end
      8'h29: begin w_base = 8'h20; w_shft = 8'h20; end
      8'h4E: begin w_base = 8'h2D; w_shft = 8'h5F; end
      8'h55: begin w_base = 8'h3D; w_shft = 8'h2B; end
      8'h54: begin w_base = 8'h5B; w_shft = 8'h7B; end
      8'h5B: begin w_base = 8'h5D; w_shft = 8'h7D; end
      8'h5D: begin w_base = 8'h5C; w_shft = 8'h7C; end
      8'h4C: begin w_base = 8'h3B; w_shft = 8'h3A; end
      8'h52: begin w_base = 8'h27; w_shft = 8'h22; end
      8'h41: begin w_base = 8'h2C; w_shft = 8'h3C; end
      8'h49: begin w_base = 8'h2E; w_shft = 8'h3E; end
      8'h4A: begin w_base = 8'h2F; w_shft = 8'h3F; end
      8'h0E: begin w_base = 8'h60; w_shft = 8'h7E; end
      default: ;
    endcase
  end

  // Letters honour caps-lock, everything else only reacts to shift.
  assign w_letter    = (w_base >= 8'h61) && (w_base <= 8'h7A);
  assign o_printable = (w_base != 8'h00);
  assign o_ascii     = w_letter ? ((i_shift ^ i_caps) ? (w_base ^ 8'h20) : w_base)
                                : (i_shift ? w_shft : w_base);

endmodule

// File: rtl/scan_ascii_dec.sv
// PS/2 set-2 byte stream to ASCII FIFO; char visible one cycle after its make byte.
// No input backpressure: a push into a full FIFO without a same-cycle pop is dropped and flagged.
module scan_ascii_dec
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int REPEAT_EN = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  input  logic             rd_en,
  output logic [7:0]       ascii,
  output logic             ascii_valid,
  output logic             fifo_full,
  output logic             overflow,
  output logic             shift_on,
  output logic             caps_on,
  output logic [CNT_W-1:0] key_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  kbd_state_t       r_state;
  logic             r_lshift;
  logic             r_rshift;
  logic             r_caps;
  logic             r_caps_held;
  logic             r_held_vld;
  logic [7:0]       r_held_code;

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_overflow;
  logic [CNT_W-1:0] r_key_cnt;

  logic [7:0]       w_xlat;
  logic             w_printable;
  logic             w_shift;
  logic             w_make;
  logic             w_repeat;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_wr;

  assign w_shift = r_lshift | r_rshift;

  // Translation sees modifier registers before this byte updates them.
  scan_xlat u_xlat (
    .i_code      (code_in),
    .i_shift     (w_shift),
    .i_caps      (r_caps),
    .o_ascii     (w_xlat),
    .o_printable (w_printable)
  );

  assign w_make   = code_valid && (r_state == ST_IDLE) && !is_prefix(code_in);
  assign w_repeat = (REPEAT_EN == 0) && r_held_vld && (r_held_code == code_in);
  assign w_push   = w_make && !w_repeat && w_printable;
  assign w_full   = (r_cnt == FULL_CNT);
  assign w_empty  = (r_cnt == '0);
  assign w_pop    = rd_en && !w_empty;
  assign w_wr     = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_held_vld  <= 1'b0;
      r_held_code <= 8'h00;
    end else if (code_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (code_in == SC_BRK) begin
            r_state <= ST_BRK;
          end else if (code_in == SC_EXT) begin
            r_state <= ST_EXT;
          end else begin
            if (code_in == SC_LSHIFT) r_lshift <= 1'b1;
            if (code_in == SC_RSHIFT) r_rshift <= 1'b1;
            if (code_in == SC_CAPS) begin
              r_caps_held <= 1'b1;
              if (!r_caps_held) r_caps <= ~r_caps;
            end
            if (!w_repeat) begin
              r_held_vld  <= 1'b1;
              r_held_code <= code_in;
            end
          end
        end
        ST_BRK: begin
          r_state <= ST_IDLE;
          if (!is_prefix(code_in)) begin
            if (code_in == SC_LSHIFT) r_lshift <= 1'b0;
            if (code_in == SC_RSHIFT) r_rshift <= 1'b0;
            if (code_in == SC_CAPS)   r_caps_held <= 1'b0;
            if (r_held_vld && (r_held_code == code_in)) r_held_vld <= 1'b0;
          end
        end
        ST_EXT:  r_state <= (code_in == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_key_cnt  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_key_cnt <= r_key_cnt + CNT_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_xlat;
  end

  assign ascii       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign ascii_valid = !w_empty;
  assign fifo_full   = w_full;
  assign overflow    = r_overflow;
  assign shift_on    = w_shift;
  assign caps_on     = r_caps;
  assign key_count   = r_key_cnt;

endmodule

// File: tb/tb_scan_ascii_dec.sv
// Drives a non-repeating and a repeating decoder with the same byte stream
// and compares both against a keyboard model built from the key tables.
module tb_scan_ascii_dec;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_in;
  logic       code_valid;
  logic       rd_en;

  logic [7:0] ascii_o [2];
  logic       av_o [2];
  logic       ff_o [2];
  logic       ov_o [2];
  logic       sh_o [2];
  logic       cp_o [2];
  logic [7:0] kc_o [2];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  scan_ascii_dec #(.DEPTH(DEPTH), .REPEAT_EN(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .rd_en(rd_en),
    .ascii(ascii_o[0]), .ascii_valid(av_o[0]), .fifo_full(ff_o[0]), .overflow(ov_o[0]),
    .shift_on(sh_o[0]), .caps_on(cp_o[0]), .key_count(kc_o[0]));

  scan_ascii_dec #(.DEPTH(DEPTH), .REPEAT_EN(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .rd_en(rd_en),
    .ascii(ascii_o[1]), .ascii_valid(av_o[1]), .fifo_full(ff_o[1]), .overflow(ov_o[1]),
    .shift_on(sh_o[1]), .caps_on(cp_o[1]), .key_count(kc_o[1]));

  // Key tables: plain and shifted glyph per scan code.
  bit         t_ok  [256];
  bit         t_let [256];
  logic [7:0] t_lo  [256];
  logic [7:0] t_hi  [256];
  logic [7:0] mapped [$];

  // Model state per instance (index = REPEAT_EN).
  bit         p_f0 [2];
  bit         p_e0 [2];
  bit         m_lsh [2];
  bit         m_rsh [2];
  bit         m_caps [2];
  bit         m_capsh [2];
  int         m_held [2];
  bit         m_ov [2];
  logic [7:0] m_kc [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  function automatic void build_tables();
    logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pc [12] = '{8'h29, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                            8'h41, 8'h49, 8'h4A, 8'h0E};
    logic [7:0] pl [12] = '{8'h20, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                            8'h2C, 8'h2E, 8'h2F, 8'h60};
    logic [7:0] ph [12] = '{8'h20, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                            8'h3C, 8'h3E, 8'h3F, 8'h7E};
    string ds = ")!@#$%^&*(";
    for (int i = 0; i < 256; i++) begin
      t_ok[i] = 0; t_let[i] = 0; t_lo[i] = 8'h00; t_hi[i] = 8'h00;
    end
    for (int i = 0; i < 26; i++) begin
      t_ok[lc[i]] = 1; t_let[lc[i]] = 1;
      t_lo[lc[i]] = 8'(8'h61 + i); t_hi[lc[i]] = 8'(8'h41 + i);
      mapped.push_back(lc[i]);
    end
    for (int i = 0; i < 10; i++) begin
      t_ok[dc[i]] = 1; t_lo[dc[i]] = 8'(8'h30 + i); t_hi[dc[i]] = ds[i];
      mapped.push_back(dc[i]);
    end
    for (int i = 0; i < 12; i++) begin
      t_ok[pc[i]] = 1; t_lo[pc[i]] = pl[i]; t_hi[pc[i]] = ph[i];
      mapped.push_back(pc[i]);
    end
  endfunction

  function automatic void mdl_reset();
    for (int m = 0; m < 2; m++) begin
      p_f0[m] = 0; p_e0[m] = 0; m_lsh[m] = 0; m_rsh[m] = 0; m_caps[m] = 0;
      m_capsh[m] = 0; m_held[m] = -1; m_ov[m] = 0; m_kc[m] = 8'd0;
    end
    q0.delete(); q1.delete();
  endfunction

  function automatic int qsize(int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qfront(int m);
    if (qsize(m) == 0) return 8'h00;
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  // Returns 1 with the glyph when this byte is a printable key press that should be queued.
  function automatic bit mdl_byte(int m, logic [7:0] b, output logic [7:0] ch);
    bit sh, push;
    push = 0; ch = 8'h00;
    if (!p_f0[m] && !p_e0[m] && b == 8'hF0) p_f0[m] = 1;
    else if (!p_f0[m] && !p_e0[m] && b == 8'hE0) p_e0[m] = 1;
    else if (p_e0[m] && !p_f0[m] && b == 8'hF0) p_f0[m] = 1;
    else begin
      if (!p_f0[m] && !p_e0[m]) begin
        sh = m_lsh[m] | m_rsh[m];
        ch = t_let[b] ? ((sh ^ m_caps[m]) ? t_hi[b] : t_lo[b]) : (sh ? t_hi[b] : t_lo[b]);
        if (m == 1 || m_held[m] != int'(b)) begin
          push = t_ok[b];
          m_held[m] = int'(b);
        end
        if (b == 8'h12) m_lsh[m] = 1;
        if (b == 8'h59) m_rsh[m] = 1;
        if (b == 8'h58) begin
          if (!m_capsh[m]) m_caps[m] = !m_caps[m];
          m_capsh[m] = 1;
        end
      end else if (p_f0[m] && !p_e0[m] && b != 8'hF0 && b != 8'hE0) begin
        if (b == 8'h12) m_lsh[m] = 0;
        if (b == 8'h59) m_rsh[m] = 0;
        if (b == 8'h58) m_capsh[m] = 0;
        if (m_held[m] == int'(b)) m_held[m] = -1;
      end
      p_f0[m] = 0; p_e0[m] = 0;
    end
    return push;
  endfunction

  function automatic void mdl_edge(int m, logic v, logic [7:0] b, logic rd);
    logic [7:0] ch;
    bit push, pop;
    push = v ? mdl_byte(m, b, ch) : 1'b0;
    pop  = rd && (qsize(m) > 0);
    if (pop) begin
      if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (push) begin
      if (qsize(m) < DEPTH) begin
        if (m == 0) q0.push_back(ch); else q1.push_back(ch);
        m_kc[m] = 8'(m_kc[m] + 1);
      end else begin
        m_ov[m] = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("ascii[%0d]", m),       16'(ascii_o[m]), 16'(qfront(m)));
      chk($sformatf("ascii_valid[%0d]", m), 16'(av_o[m]),    16'(qsize(m) > 0));
      chk($sformatf("fifo_full[%0d]", m),   16'(ff_o[m]),    16'(qsize(m) == DEPTH));
      chk($sformatf("overflow[%0d]", m),    16'(ov_o[m]),    16'(m_ov[m]));
      chk($sformatf("shift_on[%0d]", m),    16'(sh_o[m]),    16'(m_lsh[m] | m_rsh[m]));
      chk($sformatf("caps_on[%0d]", m),     16'(cp_o[m]),    16'(m_caps[m]));
      chk($sformatf("key_count[%0d]", m),   16'(kc_o[m]),    16'(m_kc[m]));
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input logic rd);
    code_valid = v; code_in = b; rd_en = rd;
    for (int m = 0; m < 2; m++) mdl_edge(m, v, b, rd);
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0; rd_en = 1'b0;
    check_all();
  endtask

  task automatic key(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic do_reset();
    code_valid = 1'b0; rd_en = 1'b0;
    rst = 1'b1;
    #1;
    mdl_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] pool [$];
    logic [7:0] prev;
    logic [7:0] b;
    logic [7:0] fill [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

    rst = 1'b1; code_valid = 1'b0; code_in = 8'h00; rd_en = 1'b0;
    build_tables();
    mdl_reset();
    @(negedge clk);
    do_reset();

    // Plain press, then its release.
    key(8'h1C);
    chk("a_char", 16'(ascii_o[0]), 16'h0061);
    chk("a_count", 16'(kc_o[0]), 16'd1);
    key(8'hF0); key(8'h1C);
    chk("a_break_count", 16'(kc_o[0]), 16'd1);
    drain();
    chk("a_drained", 16'(av_o[0]), 16'd0);

    // Shifted then unshifted digit.
    do_reset();
    key(8'h12); key(8'h16); key(8'hF0); key(8'h16); key(8'hF0); key(8'h12); key(8'h16);
    chk("shift_bang", 16'(ascii_o[0]), 16'h0021);
    cyc(1'b0, 8'h00, 1'b1);
    chk("plain_one", 16'(ascii_o[0]), 16'h0031);
    drain();

    // Caps toggled, then shift cancels it.
    do_reset();
    key(8'h58); key(8'hF0); key(8'h58); key(8'h1C); key(8'h12); key(8'h1C);
    chk("caps_latched", 16'(cp_o[0]), 16'd1);
    chk("caps_upper", 16'(ascii_o[0]), 16'h0041);
    cyc(1'b0, 8'h00, 1'b1);
    chk("caps_shift_lower", 16'(ascii_o[0]), 16'h0061);
    drain();

    // Typematic repeats.
    do_reset();
    key(8'h1C); key(8'h1C); key(8'h1C);
    chk("norep_count", 16'(kc_o[0]), 16'd1);
    chk("rep_count", 16'(kc_o[1]), 16'd3);

    // Fill to full, then overflow.
    do_reset();
    for (int i = 0; i < 8; i++) key(fill[i]);
    chk("full_at_8", 16'(ff_o[0]), 16'd1);
    key(fill[8]);
    chk("ovf_set", 16'(ov_o[0]), 16'd1);
    chk("ovf_count", 16'(kc_o[0]), 16'd8);
    chk("ovf_head", 16'(ascii_o[0]), 16'h0061);

    // Full with simultaneous pop: no drop.
    do_reset();
    for (int i = 0; i < 8; i++) key(fill[i]);
    cyc(1'b1, fill[8], 1'b1);
    chk("pushpop_ovf", 16'(ov_o[0]), 16'd0);
    chk("pushpop_full", 16'(ff_o[0]), 16'd1);
    chk("pushpop_count", 16'(kc_o[0]), 16'd9);
    chk("pushpop_head", 16'(ascii_o[0]), 16'h0062);
    drain();

    // Extended keys ignored; reset drops a pending break prefix.
    do_reset();
    key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
    chk("ext_nopush", 16'(av_o[0]), 16'd0);
    chk("ext_count", 16'(kc_o[0]), 16'd0);
    key(8'hF0);
    do_reset();
    key(8'h1C);
    chk("post_rst_valid", 16'(av_o[0]), 16'd1);
    chk("post_rst_a", 16'(ascii_o[0]), 16'h0061);

    // Random typing, including counter wrap and overflow episodes.
    do_reset();
    foreach (mapped[i]) pool.push_back(mapped[i]);
    for (int i = 0; i < 12; i++) pool.push_back(8'hF0);
    pool.push_back(8'h12); pool.push_back(8'h59); pool.push_back(8'h58); pool.push_back(8'h58);
    pool.push_back(8'hE0); pool.push_back(8'hE0); pool.push_back(8'h75); pool.push_back(8'h00);
    prev = 8'h1C;
    for (int n = 0; n < 3000; n++) begin
      b = ($urandom_range(0, 4) == 0) ? prev : pool[$urandom_range(0, pool.size() - 1)];
      prev = b;
      cyc(1'($urandom_range(0, 99) < 65), b,
          1'(((n / 400) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
